rv32_bus_dmem_rsp: RTL and testbench

- Data-bus responder: the target end of the CPU load/store bus.
- Decodes one address window and serves byte-enabled reads and writes from an internal word array.
- Adds programmable wait states, returns access errors, and keeps the LR/SC reservation set, so atomic `rvso` requests from the initiator resolve here.

---
 rtl/rv32_bus_dmem_rsp_if.sv | 27 ++
 rtl/rv32_bus_dmem_rsp.sv | 154 +++++++++++++++
 tb/tb_rv32_bus_dmem_rsp.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_bus_dmem_rsp_if.sv
// Load/store bus between a CPU data-port initiator and a memory responder.
// Request fields are held by the initiator; we/re are single-cycle pulses.
interface rv32_bus_dmem_rsp_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_data;
  logic [3:0]      req_ben;
  logic            req_we;
  logic            req_re;
  logic            req_src;
  logic            req_priv;
  logic            req_rvso;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_ack;
  logic            rsp_err;

  modport master (
    output req_addr, req_data, req_ben, req_we, req_re, req_src, req_priv, req_rvso,
    input  rsp_data, rsp_ack, rsp_err
  );

  modport slave (
    input  req_addr, req_data, req_ben, req_we, req_re, req_src, req_priv, req_rvso,
    output rsp_data, rsp_ack, rsp_err
  );
endinterface

// File: rtl/rv32_bus_dmem_rsp.sv
// Data-bus memory responder: one address window, byte-enabled word array,
// programmable wait states, access errors and the LR/SC reservation set.
module rv32_bus_dmem_rsp #(
  parameter int              XLEN       = 32,
  parameter int              ABITS      = 10,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int              PRIV_WORDS = 0,
  parameter int              LATENCY    = 1
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  rv32_bus_dmem_rsp_if.slave  bus,
  output logic                o_rsv_valid
);

  localparam int             DEPTH     = 1 << ABITS;
  localparam logic [ABITS:0] PRIV_BASE = (ABITS + 1)'(DEPTH - PRIV_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             state;
  logic [3:0]         wait_cnt;
  logic [ABITS-1:0]   cap_idx;
  logic [XLEN-1:0]    cap_data;
  logic [3:0]         cap_ben;
  logic               cap_we, cap_re, cap_src, cap_priv, cap_rvso;
  logic               do_write;
  logic [ABITS-1:0]   rsv_idx;
  logic [XLEN-1:0]    mem [DEPTH];

  logic               hit, start, to_resp;
  logic [ABITS-1:0]   cur_idx;
  logic               cur_we, cur_re, cur_src, cur_priv, cur_rvso;
  logic               cur_err, sc_ok;
  logic [XLEN-1:0]    rd_word, rsp_word;
  logic               unused_addr_lsbs;

  assign hit              = bus.req_addr[XLEN-1:ABITS+2] == BASE_ADDR[XLEN-1:ABITS+2];
  assign start            = (state == S_IDLE) && hit && (bus.req_re || bus.req_we);
  assign unused_addr_lsbs = ^bus.req_addr[1:0];

  // The response is resolved on the edge that enters RESP. With LATENCY=1 that
  // is the capture edge itself, so the live request is used instead of the copy.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_idx  = cap_idx;
    cur_we   = cap_we;
    cur_re   = cap_re;
    cur_src  = cap_src;
    cur_priv = cap_priv;
    cur_rvso = cap_rvso;
    if (state == S_IDLE) begin
      cur_idx  = bus.req_addr[ABITS+1:2];
      cur_we   = bus.req_we;
      cur_re   = bus.req_re;
      cur_src  = bus.req_src;
      cur_priv = bus.req_priv;
      cur_rvso = bus.req_rvso;
    end
  end

  assign to_resp = (start && LATENCY == 1) || (state == S_BUSY && wait_cnt == 4'd1);
  assign cur_err = (cur_re && cur_we) || (cur_we && cur_src) ||
                   (!cur_priv && {1'b0, cur_idx} >= PRIV_BASE);
  assign sc_ok   = o_rsv_valid && (rsv_idx == cur_idx);
  assign rd_word = mem[cur_idx];

  always_comb begin
    rsp_word = '0;
    if (!cur_err) begin
      if (cur_re)        rsp_word = rd_word;
      else if (cur_rvso) rsp_word = XLEN'(!sc_ok);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      cap_idx      <= '0;
      cap_data     <= '0;
      cap_ben      <= '0;
      cap_we       <= 1'b0;
      cap_re       <= 1'b0;
      cap_src      <= 1'b0;
      cap_priv     <= 1'b0;
      cap_rvso     <= 1'b0;
      do_write     <= 1'b0;
      rsv_idx      <= '0;
      o_rsv_valid  <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_ack  <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cap_idx  <= bus.req_addr[ABITS+1:2];
          cap_data <= bus.req_data;
          cap_ben  <= bus.req_ben;
          cap_we   <= bus.req_we;
          cap_re   <= bus.req_re;
          cap_src  <= bus.req_src;
          cap_priv <= bus.req_priv;
          cap_rvso <= bus.req_rvso;
          if (LATENCY == 1) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= 4'(LATENCY - 1);
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= S_RESP;
        end
        S_RESP: begin
          state        <= S_IDLE;
          bus.rsp_ack  <= 1'b0;
          bus.rsp_err  <= 1'b0;
          bus.rsp_data <= '0;
          do_write     <= 1'b0;
          if (bus.rsp_ack) begin
            if (cap_re && cap_rvso) begin
              o_rsv_valid <= 1'b1;
              rsv_idx     <= cap_idx;
            end else if (cap_we && (cap_rvso || rsv_idx == cap_idx)) begin
              o_rsv_valid <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (to_resp) begin
        bus.rsp_ack  <= !cur_err;
        bus.rsp_err  <= cur_err;
        bus.rsp_data <= rsp_word;
        do_write     <= !cur_err && cur_we && (!cur_rvso || sc_ok);
      end
    end
  end

  // NOTE: the array has no reset; its contents survive i_rstn and start undefined.
  always_ff @(posedge i_clk) begin
    if (state == S_RESP && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_ben[i]) mem[cap_idx][8*i +: 8] <= cap_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32_bus_dmem_rsp.sv
// Scoreboard bench: dut0 has LATENCY=1 and 4 machine-only words, dut1 has
// LATENCY=3. Stimulus pushes expected responses; a monitor pops and compares.
module tb_rv32_bus_dmem_rsp;

  localparam logic [31:0] B = 32'h8000_0000;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsv0, rsv1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32_bus_dmem_rsp_if #(.XLEN(32)) bus0 ();
  rv32_bus_dmem_rsp_if #(.XLEN(32)) bus1 ();

  rv32_bus_dmem_rsp #(.XLEN(32), .ABITS(10), .BASE_ADDR(B), .PRIV_WORDS(4), .LATENCY(1)) dut0 (
    .i_clk(clk), .i_rstn(rst_n), .bus(bus0), .o_rsv_valid(rsv0));

  rv32_bus_dmem_rsp #(.XLEN(32), .ABITS(10), .BASE_ADDR(B), .PRIV_WORDS(0), .LATENCY(3)) dut1 (
    .i_clk(clk), .i_rstn(rst_n), .bus(bus1), .o_rsv_valid(rsv1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_step(input int d);
    exp_t        e;
    bit          have;
    logic        ack, err;
    logic [31:0] data;
    ack  = (d == 0) ? bus0.rsp_ack  : bus1.rsp_ack;
    err  = (d == 0) ? bus0.rsp_err  : bus1.rsp_err;
    data = (d == 0) ? bus0.rsp_data : bus1.rsp_data;
    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
    e = '{ack: 1'b0, err: 1'b0, data: '0, due: 0};
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (ack !== 1'b0 || err !== 1'b0) begin
      if (!have) begin
        n_vec++;
        n_err++;
        $display("FAIL dut%0d unexpected_rsp: got ack=%b err=%b data=%h at cycle %0d, required no response",
                 d, ack, err, data, cyc);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("dut%0d rsp_cycle", d), cyc, e.due);
        check($sformatf("dut%0d rsp_ack", d), {31'b0, ack}, {31'b0, e.ack});
        check($sformatf("dut%0d rsp_err", d), {31'b0, err}, {31'b0, e.err});
        check($sformatf("dut%0d rsp_data", d), data, e.data);
      end
    end else begin
      if (have && cyc >= e.due) begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL dut%0d missing_rsp: got no response by cycle %0d, required ack=%b err=%b data=%h",
                 d, cyc, e.ack, e.err, e.data);
      end
      check($sformatf("dut%0d idle_data", d), data, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic drive(input int d, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] ben, input logic we, input logic re,
                       input logic src, input logic priv, input logic rvso);
    if (d == 0) begin
      bus0.req_addr = addr; bus0.req_data = data; bus0.req_ben = ben;
      bus0.req_we = we; bus0.req_re = re; bus0.req_src = src;
      bus0.req_priv = priv; bus0.req_rvso = rvso;
    end else begin
      bus1.req_addr = addr; bus1.req_data = data; bus1.req_ben = ben;
      bus1.req_we = we; bus1.req_re = re; bus1.req_src = src;
      bus1.req_priv = priv; bus1.req_rvso = rvso;
    end
  endtask

  task automatic clear_pulses();
    bus0.req_we = 1'b0; bus0.req_re = 1'b0;
    bus1.req_we = 1'b0; bus1.req_re = 1'b0;
  endtask

  task automatic push(input int d, input logic ack, input logic err,
                      input logic [31:0] data, input int due);
    exp_t e;
    e = '{ack: ack, err: err, data: data, due: due};
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // One request; returns once the responder is idle again with all effects done.
  task automatic req(input int d, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] ben, input logic we, input logic re,
                     input logic src, input logic priv, input logic rvso,
                     input bit expect_rsp, input logic exp_err, input logic [31:0] exp_data);
    int lat;
    lat = (d == 0) ? 1 : 3;
    @(negedge clk);
    drive(d, addr, data, ben, we, re, src, priv, rvso);
    if (expect_rsp) push(d, !exp_err, exp_err, exp_data, cyc + lat);
    @(negedge clk);
    clear_pulses();
    repeat (lat) @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ben);
    req(d, addr, data, ben, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic rd(input int d, input logic [31:0] addr, input logic [31:0] exp);
    req(d, addr, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, exp);
  endtask

  task automatic lr(input int d, input logic [31:0] addr, input logic [31:0] exp);
    req(d, addr, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, exp);
  endtask

  task automatic sc(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] status);
    req(d, addr, data, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, status);
  endtask

  initial begin
    drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset ack0", {31'b0, bus0.rsp_ack}, 32'h0);
    check("reset err0", {31'b0, bus0.rsp_err}, 32'h0);
    check("reset data0", bus0.rsp_data, 32'h0);
    check("reset rsv0", {31'b0, rsv0}, 32'h0);
    check("reset ack1", {31'b0, bus1.rsp_ack}, 32'h0);
    check("reset rsv1", {31'b0, rsv1}, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic write/read, one-cycle latency
    wr(0, B + 32'h10, 32'hDEAD_BEEF, 4'hF);
    rd(0, B + 32'h10, 32'hDEAD_BEEF);

    // Single byte lane over a zero word; addr[1:0] ignored on the read
    wr(0, B + 32'h14, 32'h0, 4'hF);
    wr(0, B + 32'h14, 32'h1122_3344, 4'b0100);
    rd(0, B + 32'h17, 32'h0022_0000);

    // LR/SC success, then SC without a reservation
    wr(0, B + 32'h20, 32'h0000_0055, 4'hF);
    lr(0, B + 32'h20, 32'h0000_0055);
    check("rsv after lr", {31'b0, rsv0}, 32'h1);
    sc(0, B + 32'h20, 32'hCAFE_F00D, 32'h0);
    check("rsv after sc", {31'b0, rsv0}, 32'h0);
    rd(0, B + 32'h20, 32'hCAFE_F00D);
    sc(0, B + 32'h20, 32'h0BAD_BEEF, 32'h1);
    rd(0, B + 32'h20, 32'hCAFE_F00D);

    // Plain write to the reserved word kills the reservation
    wr(0, B + 32'h40, 32'h4040_4040, 4'hF);
    lr(0, B + 32'h40, 32'h4040_4040);
    wr(0, B + 32'h40, 32'h1111_1111, 4'hF);
    check("rsv killed", {31'b0, rsv0}, 32'h0);
    sc(0, B + 32'h40, 32'h2222_2222, 32'h1);
    rd(0, B + 32'h40, 32'h1111_1111);

    // Write to a neighbouring word keeps it
    lr(0, B + 32'h40, 32'h1111_1111);
    wr(0, B + 32'h44, 32'h0000_0044, 4'hF);
    check("rsv kept", {31'b0, rsv0}, 32'h1);
    sc(0, B + 32'h40, 32'h3333_3333, 32'h0);
    rd(0, B + 32'h40, 32'h3333_3333);

    // Machine-only top words: 1020 is the first protected index
    req(0, B + 32'hFF0, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    req(0, B + 32'hFF0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    req(0, B + 32'hFF0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5A5A_5A5A);
    req(0, B + 32'hFEC, 32'h0102_0304, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    req(0, B + 32'hFEC, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0102_0304);

    // we+re together and fetch-side write are errors with no side effects
    req(0, B + 32'h10, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    req(0, B + 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    rd(0, B + 32'h10, 32'hDEAD_BEEF);

    // Outside the window: no response, no aliasing into the array
    req(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    req(0, B + 32'h1010, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rd(0, B + 32'h10, 32'hDEAD_BEEF);

    // Three-cycle latency
    wr(1, B + 32'h8, 32'hAAAA_5555, 4'hF);
    rd(1, B + 32'h8, 32'hAAAA_5555);

    // A write issued mid-wait is dropped
    @(negedge clk);
    drive(1, B + 32'h8, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, 1'b1, 1'b0, 32'hAAAA_5555, cyc + 3);
    @(negedge clk);
    drive(1, B + 32'hC, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clear_pulses();
    repeat (5) @(negedge clk);
    rd(1, B + 32'h8, 32'hAAAA_5555);

    // Reset while a write waits: aborted, outputs cleared
    @(negedge clk);
    drive(1, B + 32'h8, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clear_pulses();
    #2 rst_n = 1'b0;
    #1;
    check("midreset ack1", {31'b0, bus1.rsp_ack}, 32'h0);
    check("midreset err1", {31'b0, bus1.rsp_err}, 32'h0);
    check("midreset data1", bus1.rsp_data, 32'h0);
    check("midreset rsv1", {31'b0, rsv1}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(1, B + 32'h8, 32'hAAAA_5555);

    repeat (5) @(negedge clk);
    check("dut0 pending", q0.size(), 32'h0);
    check("dut1 pending", q1.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
